fetch_pc: RTL and testbench
===========================

# fetch_pc

Program-counter register and instruction-fetch sequencer sitting directly downstream of `pc_mux`. It latches the PC selected by `pc_mux` and drives `pc + 4` back as the mux's `next` input. It issues one instruction-memory request at a time over a valid/ready handshake and presents the returned instruction, tagged with its PC, to decode through a registered valid/ready output. Redirects from branch resolution flush in-flight work.

## Interface
Parameters:
- `RESET_ADDR`, default `'h0000_0000`: PC loaded on reset; must be word aligned.

Ports:
- `clk`  in  1: single clock; all state updates on rising edge.
- `reset`  in  1: synchronous, active-high.
- `pc_mux_out`  in  32: PC selected by `pc_mux`; loaded into the PC register.
- `redirect`  in  1: high when `pc_mux` selects `BRANCH`; flushes in-flight fetch.
- `pc_mux_next`  out  32: `pc + 4`, fed to `pc_mux` `next` input (combinational from PC register).
- `imem_req_valid`  out  1: fetch request valid.
- `imem_req_ready`  in  1: memory accepts request.
- `imem_addr`  out  32: fetch address (= PC register).
- `imem_rsp_valid`  in  1: response data valid (one-cycle pulse, exactly one per accepted request).
- `imem_rsp_data`  in  32: instruction word.
- `if_valid`  out  1: instruction available to decode.
- `if_ready`  in  1: decode consumes the instruction.
- `if_pc`  out  32: PC of the presented instruction.
- `if_instr`  out  32: presented instruction.

## Operation
- State machine: `BOOT`, `REQ`, `WAIT`, `DROP`, `HOLD`.
- Reset: PC = `RESET_ADDR`, state `BOOT`, `imem_req_valid` = 0, `if_valid` = 0, `if_pc` = 0, `if_instr` = 0, skid buffer empty.
- `BOOT`: no request; go to `REQ` next cycle.
- `REQ`: `imem_req_valid` = 1, `imem_addr` = PC. On `imem_req_ready`: record PC in `req_pc`, PC <= `pc_mux_out`, go to `WAIT`.
- `WAIT`: on `imem_rsp_valid`: if output slot empty or `if_ready` this cycle, load `if_pc` <= `req_pc`, `if_instr` <= data, `if_valid` <= 1, go to `REQ`. Otherwise capture into skid buffer and go to `HOLD`.
- `HOLD`: no request. When `if_ready`, skid moves to output (`if_valid` stays 1), go to `REQ`.
- `DROP`: waiting for the response of a squashed request. On `imem_rsp_valid`, discard data and go to `REQ`.
- Output slot: `if_valid` clears when `if_ready && if_valid` and no new instruction loads that cycle.
- Redirect (highest priority below reset), any state: PC <= `pc_mux_out`, `if_valid` <= 0, skid cleared.
  - `REQ` with acceptance the same cycle: accepted request is stale, go to `DROP`.
  - `REQ` without acceptance: stay in `REQ`. Only in this case may `imem_addr` change while `imem_req_valid` is high and unacknowledged.
  - `WAIT` with no response this cycle: go to `DROP`.
  - `WAIT` with response this cycle: discard the response, go to `REQ`.
  - `HOLD`: go to `REQ`.
  - `DROP`: stay in `DROP`.
  - `BOOT`: go to `REQ`.
- Arithmetic and width rules:
  - PC loads `{pc_mux_out[31:2], 2'b00}`; low bits are ignored.
  - `pc_mux_next` = PC + 4 modulo 2^32, so `0xFFFF_FFFC` wraps to `0x0000_0000`.
- At most one outstanding memory request at any time.

## Timing
- After reset deasserts at cycle 0: `BOOT` at cycle 0, first `imem_req_valid` at cycle 1 with `imem_addr` = `RESET_ADDR`.
- Response arrives no earlier than the cycle after acceptance.
- Response at cycle N gives `if_valid` at N+1 (registered output).
- Peak throughput is one instruction per 2 cycles (`REQ`, `WAIT`) with a ready memory responding in 1 cycle.
- A redirect at cycle N deasserts `if_valid` at N+1; the new target is requested from N+1 (or after the squashed response in `DROP`).
- `pc_mux_next` follows the PC register combinationally with zero latency.

## Test plan
- Reset with `RESET_ADDR`=`'h100`, `imem_req_ready`=1, 1-cycle memory, `if_ready`=1, mux always NEXT -> requests at `'h100`, `'h104`, `'h108`, every 2 cycles. `if_pc` matches each address; first `if_valid` 3 cycles after reset deassert.
- Decode backpressure: `if_ready`=0 for 6 cycles -> exactly one instruction buffered in skid, state `HOLD`, no new request. On `if_ready`=1, both instructions delivered in order with no loss.
- Redirect to `'h200` while in `WAIT`, response 2 cycles later -> stale response discarded, `if_valid` 0. Next request at `'h200` and next `if_pc` = `'h200`.
- Redirect coinciding with request acceptance and with response arrival (separate runs) -> stale instruction never reaches decode; fetch resumes at the target.
- PC wrap: `RESET_ADDR`=`'hFFFF_FFFC` -> `pc_mux_next` = 0; second request at `'h0000_0000`.
- Reset asserted mid-`WAIT` and mid-`HOLD` -> next cycle all outputs at reset values; the late memory response is ignored; fetch restarts at `RESET_ADDR`.

Source files
------------

// File: rtl/fetch_pc.sv
// Program counter and single-outstanding instruction fetch sequencer.
// Latches the PC chosen by pc_mux, fetches one word at a time, and hands it to decode.
module fetch_pc #(
   parameter logic [31:0] RESET_ADDR = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] pc_mux_out,
   input  logic        redirect,
   output logic [31:0] pc_mux_next,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_addr,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rsp_data,
   output logic        if_valid,
   input  logic        if_ready,
   output logic [31:0] if_pc,
   output logic [31:0] if_instr
);

   typedef enum logic [2:0] {BOOT, REQ, WAIT, DROP, HOLD} state_t;

   state_t      state, state_nx;
   logic [31:0] pc, req_pc, pc_aligned;
   logic        skid_valid;
   logic [31:0] skid_pc, skid_instr;
   logic        accept, rsp_in_wait, deliver;

   assign pc_aligned     = pc_mux_out & 32'hFFFF_FFFC;
   assign pc_mux_next    = pc + 32'd4;
   assign imem_req_valid = (state == REQ);
   assign imem_addr      = pc;

   assign accept      = (state == REQ) && imem_req_ready;
   assign rsp_in_wait = (state == WAIT) && imem_rsp_valid;
   assign deliver     = rsp_in_wait && (!if_valid || if_ready);

   always_comb begin
      state_nx = state;
      case (state)
         BOOT: state_nx = REQ;
         REQ:  if (accept) state_nx = redirect ? DROP : WAIT;
         WAIT: begin
            if (imem_rsp_valid) state_nx = (redirect || deliver) ? REQ : HOLD;
            else if (redirect)  state_nx = DROP;
         end
         HOLD: if (redirect || if_ready) state_nx = REQ;
         // The squashed response retires the only outstanding request, even
         // if another redirect lands the same cycle.
         DROP: if (imem_rsp_valid) state_nx = REQ;
         default: state_nx = BOOT;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= BOOT;
         pc         <= RESET_ADDR;
         req_pc     <= 32'h0;
         if_valid   <= 1'b0;
         if_pc      <= 32'h0;
         if_instr   <= 32'h0;
         skid_valid <= 1'b0;
         skid_pc    <= 32'h0;
         skid_instr <= 32'h0;
      end else begin
         state <= state_nx;
         if (redirect || accept) pc <= pc_aligned;
         if (accept) req_pc <= pc;

         if (redirect) begin
            if_valid   <= 1'b0;
            skid_valid <= 1'b0;
         end else if (deliver) begin
            if_valid <= 1'b1;
            if_pc    <= req_pc;
            if_instr <= imem_rsp_data;
         end else if (state == HOLD && if_ready && skid_valid) begin
            if_pc      <= skid_pc;
            if_instr   <= skid_instr;
            skid_valid <= 1'b0;
         end else begin
            // Output is full and not draining: park the response in the skid.
            if (rsp_in_wait) begin
               skid_valid <= 1'b1;
               skid_pc    <= req_pc;
               skid_instr <= imem_rsp_data;
            end
            if (if_valid && if_ready) if_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_fetch_pc.sv
// Directed bench for fetch_pc: streaming, backpressure, redirects, PC wrap, mid-flight reset.
module tb_fetch_pc;

   localparam logic [31:0] K = 32'h5A5A_0000;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        redirect = 1'b0;
   logic [31:0] target = 32'h0;
   logic [31:0] mux_out, next_pc, addr;
   logic        req_valid, req_ready = 1'b1;
   logic        rsp_valid = 1'b0;
   logic [31:0] rsp_data = 32'h0;
   logic        if_valid, if_ready = 1'b1;
   logic [31:0] if_pc, if_instr;

   logic [31:0] w_next, w_addr, w_if_pc, w_if_instr;
   logic        w_req_valid, w_if_valid;
   logic        w_rsp = 1'b0;

   int lat = 1;
   int cnt = 0;
   logic [31:0] paddr = 32'h0;
   logic        m_acc, m_wacc;
   logic [31:0] m_a;
   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   assign mux_out = redirect ? target : next_pc;

   fetch_pc #(.RESET_ADDR(32'h0000_0100)) u_dut (
      .clk(clk), .reset(reset), .pc_mux_out(mux_out), .redirect(redirect),
      .pc_mux_next(next_pc), .imem_req_valid(req_valid), .imem_req_ready(req_ready),
      .imem_addr(addr), .imem_rsp_valid(rsp_valid), .imem_rsp_data(rsp_data),
      .if_valid(if_valid), .if_ready(if_ready), .if_pc(if_pc), .if_instr(if_instr));

   fetch_pc #(.RESET_ADDR(32'hFFFF_FFFC)) u_wrap (
      .clk(clk), .reset(reset), .pc_mux_out(w_next), .redirect(1'b0),
      .pc_mux_next(w_next), .imem_req_valid(w_req_valid), .imem_req_ready(1'b1),
      .imem_addr(w_addr), .imem_rsp_valid(w_rsp), .imem_rsp_data(32'h0),
      .if_valid(w_if_valid), .if_ready(1'b1), .if_pc(w_if_pc), .if_instr(w_if_instr));

   // Memory: answers each accepted request exactly once, lat cycles later.
   always @(posedge clk) begin
      m_acc  = req_valid && req_ready && !reset;
      m_a    = addr;
      m_wacc = w_req_valid && !reset;
      #1;
      rsp_valid = 1'b0;
      w_rsp     = m_wacc;
      if (m_acc) begin cnt = lat; paddr = m_a; end
      if (cnt > 0) begin
         cnt = cnt - 1;
         if (cnt == 0) begin rsp_valid = 1'b1; rsp_data = paddr ^ K; end
      end
   end

   task tick;
      @(posedge clk); #1;
   endtask

   task do_reset;
      reset = 1'b1; redirect = 1'b0; if_ready = 1'b1;
      repeat (4) tick;
      reset = 1'b0;
   endtask

   task test_reset;
      do_reset;
      checks++; if ({req_valid, if_valid, if_pc, if_instr} !== 66'h0) begin errors++;
         $display("FAIL reset_outs got %h want 0", {req_valid, if_valid, if_pc, if_instr}); end
      checks++; if ({addr, next_pc} !== {32'h100, 32'h104}) begin errors++;
         $display("FAIL reset_pc got %h want %h", {addr, next_pc}, {32'h100, 32'h104}); end
   endtask

   task test_stream;
      logic [31:0] a;
      do_reset;
      tick;
      for (int i = 0; i < 4; i++) begin
         a = 32'h100 + 32'(4 * i);
         checks++; if ({req_valid, addr} !== {1'b1, a}) begin errors++;
            $display("FAIL stream_req%0d got %h want %h", i, {req_valid, addr}, {1'b1, a}); end
         tick;
         checks++; if (if_valid !== 1'b0) begin errors++;
            $display("FAIL stream_gap%0d got %b want 0", i, if_valid); end
         tick;
         checks++; if ({if_valid, if_pc, if_instr} !== {1'b1, a, a ^ K}) begin errors++;
            $display("FAIL stream_out%0d got %h want %h", i, {if_valid, if_pc, if_instr}, {1'b1, a, a ^ K}); end
      end
   endtask

   task test_backpressure;
      do_reset;
      tick; tick;
      if_ready = 1'b0;
      tick;
      checks++; if ({if_valid, if_pc} !== {1'b1, 32'h100}) begin errors++;
         $display("FAIL bp_first got %h want %h", {if_valid, if_pc}, {1'b1, 32'h100}); end
      tick;
      for (int c = 5; c <= 8; c++) begin
         tick;
         checks++; if ({req_valid, if_valid, if_pc} !== {2'b01, 32'h100}) begin errors++;
            $display("FAIL bp_hold%0d got %h want %h", c, {req_valid, if_valid, if_pc}, {2'b01, 32'h100}); end
      end
      if_ready = 1'b1;
      tick;
      checks++; if ({if_valid, if_pc, if_instr} !== {1'b1, 32'h104, 32'h104 ^ K}) begin errors++;
         $display("FAIL bp_skid got %h want %h", {if_valid, if_pc, if_instr}, {1'b1, 32'h104, 32'h104 ^ K}); end
      checks++; if ({req_valid, addr} !== {1'b1, 32'h108}) begin errors++;
         $display("FAIL bp_resume got %h want %h", {req_valid, addr}, {1'b1, 32'h108}); end
      tick; tick;
      checks++; if ({if_valid, if_pc} !== {1'b1, 32'h108}) begin errors++;
         $display("FAIL bp_next got %h want %h", {if_valid, if_pc}, {1'b1, 32'h108}); end
   endtask

   task test_redirect_wait;
      do_reset;
      if_ready = 1'b0;
      tick; tick; tick;
      checks++; if ({if_valid, if_pc} !== {1'b1, 32'h100}) begin errors++;
         $display("FAIL rw_first got %h want %h", {if_valid, if_pc}, {1'b1, 32'h100}); end
      lat = 3;
      tick;
      redirect = 1'b1; target = 32'h200;
      tick;
      redirect = 1'b0; if_ready = 1'b1;
      checks++; if ({if_valid, req_valid, addr} !== {2'b00, 32'h200}) begin errors++;
         $display("FAIL rw_flush got %h want %h", {if_valid, req_valid, addr}, {2'b00, 32'h200}); end
      tick; tick;
      checks++; if ({if_valid, req_valid, addr} !== {2'b01, 32'h200}) begin errors++;
         $display("FAIL rw_req got %h want %h", {if_valid, req_valid, addr}, {2'b01, 32'h200}); end
      for (int c = 8; c <= 10; c++) begin
         tick;
         checks++; if (if_valid !== 1'b0) begin errors++;
            $display("FAIL rw_stale%0d got %b want 0", c, if_valid); end
      end
      tick;
      checks++; if ({if_valid, if_pc, if_instr} !== {1'b1, 32'h200, 32'h200 ^ K}) begin errors++;
         $display("FAIL rw_target got %h want %h", {if_valid, if_pc, if_instr}, {1'b1, 32'h200, 32'h200 ^ K}); end
      lat = 1;
   endtask

   task test_redirect_accept;
      do_reset;
      if_ready = 1'b0;
      tick; tick; tick;
      redirect = 1'b1; target = 32'h300;
      tick;
      redirect = 1'b0; if_ready = 1'b1;
      checks++; if ({if_valid, req_valid, addr} !== {2'b00, 32'h300}) begin errors++;
         $display("FAIL ra_flush got %h want %h", {if_valid, req_valid, addr}, {2'b00, 32'h300}); end
      tick;
      checks++; if ({if_valid, req_valid, addr} !== {2'b01, 32'h300}) begin errors++;
         $display("FAIL ra_req got %h want %h", {if_valid, req_valid, addr}, {2'b01, 32'h300}); end
      tick;
      checks++; if (if_valid !== 1'b0) begin errors++;
         $display("FAIL ra_stale got %b want 0", if_valid); end
      tick;
      checks++; if ({if_valid, if_pc} !== {1'b1, 32'h300}) begin errors++;
         $display("FAIL ra_target got %h want %h", {if_valid, if_pc}, {1'b1, 32'h300}); end
   endtask

   task test_redirect_rsp;
      do_reset;
      tick; tick;
      redirect = 1'b1; target = 32'h403;
      tick;
      redirect = 1'b0;
      checks++; if ({if_valid, req_valid, addr} !== {2'b01, 32'h400}) begin errors++;
         $display("FAIL rr_req got %h want %h", {if_valid, req_valid, addr}, {2'b01, 32'h400}); end
      tick;
      checks++; if (if_valid !== 1'b0) begin errors++;
         $display("FAIL rr_stale got %b want 0", if_valid); end
      tick;
      checks++; if ({if_valid, if_pc, if_instr} !== {1'b1, 32'h400, 32'h400 ^ K}) begin errors++;
         $display("FAIL rr_target got %h want %h", {if_valid, if_pc, if_instr}, {1'b1, 32'h400, 32'h400 ^ K}); end
   endtask

   task test_wrap;
      do_reset;
      checks++; if ({w_req_valid, w_addr, w_next} !== {1'b0, 32'hFFFF_FFFC, 32'h0}) begin errors++;
         $display("FAIL wrap_next got %h want %h", {w_req_valid, w_addr, w_next}, {1'b0, 32'hFFFF_FFFC, 32'h0}); end
      tick;
      checks++; if ({w_req_valid, w_addr} !== {1'b1, 32'hFFFF_FFFC}) begin errors++;
         $display("FAIL wrap_req0 got %h want %h", {w_req_valid, w_addr}, {1'b1, 32'hFFFF_FFFC}); end
      tick; tick;
      checks++; if ({w_req_valid, w_addr, w_if_valid, w_if_pc} !== {1'b1, 32'h0, 1'b1, 32'hFFFF_FFFC}) begin errors++;
         $display("FAIL wrap_req1 got %h want %h", {w_req_valid, w_addr, w_if_valid, w_if_pc}, {1'b1, 32'h0, 1'b1, 32'hFFFF_FFFC}); end
   endtask

   task test_reset_mid;
      do_reset;
      lat = 3;
      tick; tick;
      reset = 1'b1;
      tick;
      checks++; if ({req_valid, if_valid, if_pc, if_instr, addr} !== {66'h0, 32'h100}) begin errors++;
         $display("FAIL rm_wait got %h want %h", {req_valid, if_valid, if_pc, if_instr, addr}, {66'h0, 32'h100}); end
      reset = 1'b0;
      tick;
      checks++; if ({req_valid, addr} !== {1'b1, 32'h100}) begin errors++;
         $display("FAIL rm_restart got %h want %h", {req_valid, addr}, {1'b1, 32'h100}); end
      for (int c = 4; c <= 7; c++) begin
         checks++; if (if_valid !== 1'b0) begin errors++;
            $display("FAIL rm_late%0d got %b want 0", c, if_valid); end
         tick;
      end
      checks++; if ({if_valid, if_pc} !== {1'b1, 32'h100}) begin errors++;
         $display("FAIL rm_first got %h want %h", {if_valid, if_pc}, {1'b1, 32'h100}); end
      lat = 1;
      do_reset;
      if_ready = 1'b0;
      repeat (5) tick;
      checks++; if ({req_valid, if_valid} !== 2'b01) begin errors++;
         $display("FAIL rm_inhold got %b want 01", {req_valid, if_valid}); end
      reset = 1'b1;
      tick;
      checks++; if ({req_valid, if_valid, if_pc, if_instr} !== 66'h0) begin errors++;
         $display("FAIL rm_hold got %h want 0", {req_valid, if_valid, if_pc, if_instr}); end
      reset = 1'b0; if_ready = 1'b1;
      tick;
      checks++; if ({req_valid, addr} !== {1'b1, 32'h100}) begin errors++;
         $display("FAIL rm_hreq got %h want %h", {req_valid, addr}, {1'b1, 32'h100}); end
      tick; tick;
      checks++; if ({if_valid, if_pc} !== {1'b1, 32'h100}) begin errors++;
         $display("FAIL rm_hout got %h want %h", {if_valid, if_pc}, {1'b1, 32'h100}); end
   endtask

   initial begin
      test_reset;
      test_stream;
      test_backpressure;
      test_redirect_wait;
      test_redirect_accept;
      test_redirect_rsp;
      test_wrap;
      test_reset_mid;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
